// File: rtl/disp_bcd_ctrl_pkg.sv
// Shared types and constants for the BCD display controller: FSM state encoding,
// seven-segment codes (active-low, dp in bit 7) and converter widths.
package disp_bcd_ctrl_pkg;

  localparam int IN_W       = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int NUM_AN     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/disp_bcd_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, with a one-entry
// newest-wins pending register so values arriving while busy are not dropped.
module bin2bcd_seq
  import disp_bcd_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              busy,
  output logic              bcd_valid,
  output logic [BCD_W-1:0]  bcd_out
);

  bcd_state_t        state_q, state_d;
  logic              load;
  logic              last_shift;
  logic [IN_W-1:0]   start_data;
  logic              pend_q;
  logic [IN_W-1:0]   pend_data_q;
  logic              pend_capture;
  logic [3:0]        bit_cnt_q;
  logic [IN_W-1:0]   bin_q;
  logic [BCD_W-1:0]  bcd_work_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_nxt;
  logic              vld_p1;
  logic [BCD_W-1:0]  bcd_p1;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    load       = 1'b0;
    last_shift = 1'b0;
    start_data = in_data;
    case (state_q)
      IDLE: begin
        // A queued value goes first; a simultaneous new arrival is parked instead.
        if (pend_q) begin
          load       = 1'b1;
          start_data = pend_data_q;
          state_d    = SHIFT;
        end else if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (bit_cnt_q == 4'd15) begin
          last_shift = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pend_capture = in_valid && (busy || pend_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pend_q <= 1'b0;
    else if (pend_capture)      pend_q <= 1'b1;
    else if (load)              pend_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (pend_capture) pend_data_q <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  bit_cnt_q <= 4'd0;
    else if (load)            bit_cnt_q <= 4'd0;
    else if (state_q == SHIFT) bit_cnt_q <= bit_cnt_q + 4'd1;
  end

  assign bcd_adj = add3(bcd_work_q);
  assign bcd_nxt = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};

  always_ff @(posedge clk) begin
    if (load) begin
      bin_q      <= start_data;
      bcd_work_q <= '0;
    end else if (state_q == SHIFT) begin
      bin_q      <= {bin_q[IN_W-2:0], 1'b0};
      bcd_work_q <= bcd_nxt;
    end
  end

  // ---- output stage: result and its valid leave together ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      bcd_p1 <= '0;
    end else begin
      vld_p1 <= last_shift;
      if (last_shift) bcd_p1 <= bcd_nxt;
    end
  end

  assign bcd_valid = vld_p1;
  assign bcd_out   = bcd_p1;

endmodule

// File: rtl/disp_bcd_ctrl.sv
// Binary-to-BCD display controller with 8-digit multiplexed scan.
// Define DISP_LEADING_ZERO_BLANK_EN to blank leading zeros on digits 4..1.
module disp_bcd_ctrl
  import disp_bcd_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  output logic              busy,
  output logic              bcd_valid,
  output logic [BCD_W-1:0]  bcd_out,
  output logic [NUM_AN-1:0] an,
  output logic [7:0]        dec_ddp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       digit_idx;
  logic [4:0]       lz;
  logic [3:0]       nib;
  logic             in_range;

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .bcd_out   (bcd_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
    end else if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + CNT_W'(1);
    end
  end

  assign an = ~(NUM_AN'(1) << digit_idx);

  // lz[i] set means digit i and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    lz = '0;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    lz[4] = (bcd_out[19:16] == 4'd0);
    lz[3] = lz[4] && (bcd_out[15:12] == 4'd0);
    lz[2] = lz[3] && (bcd_out[11:8] == 4'd0);
    lz[1] = lz[2] && (bcd_out[7:4] == 4'd0);
`endif
  end

  always_comb begin
    nib      = 4'd0;
    in_range = 1'b1;
    case (digit_idx)
      3'd0:    nib = bcd_out[3:0];
      3'd1:    nib = bcd_out[7:4];
      3'd2:    nib = bcd_out[11:8];
      3'd3:    nib = bcd_out[15:12];
      3'd4:    nib = bcd_out[19:16];
      default: in_range = 1'b0;
    endcase
  end

  always_comb begin
    dec_ddp = SEG_BLANK;
    if (in_range && !lz[digit_idx[2] ? 4 : digit_idx[1:0]]) dec_ddp = seg_decode(nib);
  end

endmodule

// File: tb/tb_disp_bcd_ctrl.sv
// Directed self-checking bench for disp_bcd_ctrl (REFRESH_DIV=4).
// Expected scan images follow DISP_LEADING_ZERO_BLANK_EN when it is defined.
module tb_disp_bcd_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd_out;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;

  int tests = 0;
  int fails = 0;

  disp_bcd_ctrl #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .bcd_valid(bcd_valid), .bcd_out(bcd_out),
    .an(an), .dec_ddp(dec_ddp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one value and returns the number of edges until bcd_valid (edge that samples in_valid = 1).
  task automatic send_wait(input logic [15:0] v, output int lat);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!bcd_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic get_seg(input int k, output logic [7:0] seg);
    int n;
    logic [7:0] want_an;
    want_an = ~(8'd1 << k);
    n = 0;
    while (an !== want_an && n < 64) begin
      tick();
      n++;
    end
    tests++;
    if (an !== want_an) begin
      fails++;
      $display("FAIL scan_wait digit%0d: an=%h never reached required %h", k, an, want_an);
    end
    seg = dec_ddp;
  endtask

  task automatic check_digits(input string name, input logic [7:0] exp [8]);
    logic [7:0] s;
    for (int k = 0; k < 8; k++) begin
      get_seg(k, s);
      tests++;
      if (s !== exp[k]) begin
        fails++;
        $display("FAIL %s digit%0d: dec_ddp=%h required %h", name, k, s, exp[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    #2;
    tests++;
    if ({busy, bcd_valid, bcd_out, an, dec_ddp} !== {1'b0, 1'b0, 20'h0, 8'hFE, 8'hC0}) begin
      fails++;
      $display("FAIL reset_state: busy=%b vld=%b bcd=%h an=%h seg=%h required 0 0 00000 fe c0",
               busy, bcd_valid, bcd_out, an, dec_ddp);
    end
    tick(); tick();
    tests++;
    if (an !== 8'hFE || dec_ddp !== 8'hC0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: an=%h seg=%h busy=%b required fe c0 0", an, dec_ddp, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_1234();
    int lat;
    logic [7:0] exp [8];
    send_wait(16'd1234, lat);
    tests++;
    if (lat !== 17) begin
      fails++;
      $display("FAIL lat_1234: latency=%0d required 17", lat);
    end
    tests++;
    if (bcd_out !== 20'h01234) begin
      fails++;
      $display("FAIL bcd_1234: bcd_out=%h required 01234", bcd_out);
    end
    tick();
    tests++;
    if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL pulse_1234: bcd_valid=%b busy=%b one cycle after pulse, required 0 0", bcd_valid, busy);
    end
`ifdef DISP_LEADING_ZERO_BLANK_EN
    exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
`endif
    check_digits("scan_1234", exp);
  endtask

  task automatic test_max();
    int lat;
    logic [7:0] exp [8];
    send_wait(16'd65535, lat);
    tests++;
    if (lat !== 17 || bcd_out !== 20'h65535) begin
      fails++;
      $display("FAIL bcd_65535: latency=%0d bcd_out=%h required 17 65535", lat, bcd_out);
    end
    exp = '{8'h92, 8'hB0, 8'h92, 8'h92, 8'h82, 8'hFF, 8'hFF, 8'hFF};
    check_digits("scan_65535", exp);
    tests++;
    if (bcd_out !== 20'h65535) begin
      fails++;
      $display("FAIL hold_65535: bcd_out=%h required 65535", bcd_out);
    end
  endtask

  task automatic test_zero();
    int lat;
    logic [7:0] exp [8];
    send_wait(16'd0, lat);
    tests++;
    if (lat !== 17 || bcd_out !== 20'h00000) begin
      fails++;
      $display("FAIL bcd_0: latency=%0d bcd_out=%h required 17 00000", lat, bcd_out);
    end
`ifdef DISP_LEADING_ZERO_BLANK_EN
    exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
    exp = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
`endif
    check_digits("scan_0", exp);
  endtask

  task automatic test_back_to_back();
    int npulse;
    int pc [4];
    logic [19:0] pv [4];
    npulse = 0;
    for (int c = 1; c <= 60; c++) begin
      in_valid = (c == 1) || (c == 4) || (c == 7);
      in_data  = (c == 1) ? 16'd100 : (c == 4) ? 16'd200 : 16'd300;
      tick();
      if (bcd_valid && npulse < 4) begin
        pc[npulse] = c;
        pv[npulse] = bcd_out;
        npulse++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (npulse !== 2) begin
      fails++;
      $display("FAIL b2b_count: pulses=%0d required 2", npulse);
    end else begin
      tests++;
      if (pv[0] !== 20'h00100 || pv[1] !== 20'h00300) begin
        fails++;
        $display("FAIL b2b_values: %h %h required 00100 00300", pv[0], pv[1]);
      end
      tests++;
      if (pc[0] !== 17 || pc[1] - pc[0] !== 18) begin
        fails++;
        $display("FAIL b2b_timing: first=%0d gap=%0d required 17 18", pc[0], pc[1] - pc[0]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int spurious;
    int lat;
    in_valid = 1'b1;
    in_data  = 16'd4321;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    #1;
    tests++;
    if (bcd_valid !== 1'b0 || bcd_out !== 20'h0 || an !== 8'hFE || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: vld=%b bcd=%h an=%h busy=%b required 0 00000 fe 0",
               bcd_valid, bcd_out, an, busy);
    end
    tick(); tick();
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bcd_valid || busy) spurious++;
    end
    tests++;
    if (spurious !== 0 || bcd_out !== 20'h0) begin
      fails++;
      $display("FAIL abort_quiet: active cycles=%0d bcd=%h required 0 00000", spurious, bcd_out);
    end
    send_wait(16'd7, lat);
    tests++;
    if (lat !== 17 || bcd_out !== 20'h00007) begin
      fails++;
      $display("FAIL after_abort: latency=%0d bcd_out=%h required 17 00007", lat, bcd_out);
    end
  endtask

  task automatic test_scan();
    int prev, cur, dwell, wraps, bad_hot, bad_order, bad_dwell;
    bit first;
    prev = -1; dwell = 0; wraps = 0; first = 1'b1;
    bad_hot = 0; bad_order = 0; bad_dwell = 0;
    for (int c = 0; c < 340; c++) begin
      tick();
      if ($countones(~an) != 1) bad_hot++;
      cur = -1;
      for (int i = 0; i < 8; i++) if (an[i] == 1'b0) cur = i;
      dwell++;
      if (cur != prev) begin
        if (prev >= 0) begin
          if (cur != (prev + 1) % 8) bad_order++;
          if (!first && dwell != 4) bad_dwell++;
          if (prev == 7) wraps++;
          first = 1'b0;
        end
        dwell = 0;
        prev = cur;
      end
    end
    tests++;
    if (bad_hot !== 0) begin
      fails++;
      $display("FAIL scan_onehot: bad cycles=%0d required 0", bad_hot);
    end
    tests++;
    if (bad_order !== 0 || bad_dwell !== 0 || wraps < 10) begin
      fails++;
      $display("FAIL scan_order: order errs=%0d dwell errs=%0d wraps=%0d required 0 0 >=10",
               bad_order, bad_dwell, wraps);
    end
  endtask

  initial begin
    test_reset();
    test_1234();
    test_max();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    test_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
